// File: rtl/gnn_pkg.sv
// Shared types and helpers for the GNN datapath blocks.
package gnn_pkg;

  localparam int NUM_NODES = 4;
  localparam int NUM_FEAT  = 4;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} comb_state_t;

  // ReLU followed by a clamp to the largest positive value of an out_width-bit signed result.
  function automatic logic [31:0] sat_relu(input logic signed [31:0] acc, input int out_width);
    logic signed [31:0] max_val;
    max_val = (32'sd1 <<< (out_width - 1)) - 32'sd1;
    if (acc < 0)
      return '0;
    else if (acc > max_val)
      return max_val;
    else
      return acc;
  endfunction

endpackage

// File: rtl/gnn_mac.sv
// Signed multiply-accumulate with a registered accumulator; sum is the value the next enabled edge stores.
module gnn_mac #(
  parameter int A_WIDTH   = 7,
  parameter int B_WIDTH   = 5,
  parameter int ACC_WIDTH = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        load,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic signed [ACC_WIDTH-1:0] sum
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [P_WIDTH-1:0]   a_ext;
  logic signed [P_WIDTH-1:0]   b_ext;
  logic signed [P_WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc;

  always_comb begin
    a_ext    = {{B_WIDTH{a[A_WIDTH-1]}}, a};
    b_ext    = {{A_WIDTH{b[B_WIDTH-1]}}, b};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_WIDTH-P_WIDTH){prod[P_WIDTH-1]}}, prod};
    sum      = load ? prod_ext : acc + prod_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (en)
      acc <= sum;
  end

endmodule

// File: rtl/combination_engine.sv
// GNN combination stage: y[n][j] = sat(ReLU(sum_k agg[n][k]*W[k][j])) using one time-multiplexed MAC.
// state   | meaning
// IDLE    | waiting for a graph; weight writes accepted
// COMPUTE | 64 MAC cycles, cnt = {n, j, k}
// DONE    | one-cycle ready pulse
module combination_engine
  import gnn_pkg::*;
#(
  parameter int IN_WIDTH  = 7,
  parameter int W_WIDTH   = 5,
  parameter int OUT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_ready_combination,
  input  logic [16*IN_WIDTH-1:0]   agg_flat,
  input  logic                     w_we,
  input  logic [3:0]               w_addr,
  input  logic [W_WIDTH-1:0]       w_data,
  output logic [16*OUT_WIDTH-1:0]  comb_flat,
  output logic                     out_ready_combination,
  output logic                     busy,
  output logic                     err_drop
);

  localparam int ACC_WIDTH = IN_WIDTH + W_WIDTH + 2;
  localparam int NUM_IN    = NUM_NODES * NUM_FEAT;

  comb_state_t state, state_nxt;
  logic [5:0]  cnt;
  logic [1:0]  n_idx, j_idx, k_idx;

  logic signed [W_WIDTH-1:0]   weights [NUM_IN];
  logic signed [IN_WIDTH-1:0]  feats   [NUM_IN];
  logic signed [IN_WIDTH-1:0]  mac_a;
  logic signed [W_WIDTH-1:0]   mac_b;
  logic signed [ACC_WIDTH-1:0] mac_sum;
  logic [OUT_WIDTH-1:0]        sat_val;

  assign {n_idx, j_idx, k_idx} = cnt;
  assign mac_a   = feats[{n_idx, k_idx}];
  assign mac_b   = weights[{k_idx, j_idx}];
  assign sat_val = OUT_WIDTH'(sat_relu(32'(mac_sum), OUT_WIDTH));

  gnn_mac #(
    .A_WIDTH   (IN_WIDTH),
    .B_WIDTH   (W_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == COMPUTE),
    .load  (k_idx == 2'd0),
    .a     (mac_a),
    .b     (mac_b),
    .sum   (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_ready_combination) state_nxt = COMPUTE;
      COMPUTE: if (cnt == 6'd63) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy                  = (state != IDLE);
    out_ready_combination = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      err_drop  <= 1'b0;
      comb_flat <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        weights[i] <= '0;
        feats[i]   <= '0;
      end
    end else begin
      if (in_ready_combination && state != IDLE)
        err_drop <= 1'b1;
      case (state)
        IDLE: begin
          if (w_we)
            weights[w_addr] <= w_data;
          if (in_ready_combination) begin
            cnt <= '0;
            for (int i = 0; i < NUM_IN; i++)
              feats[i] <= agg_flat[i*IN_WIDTH +: IN_WIDTH];
          end
        end
        COMPUTE: begin
          cnt <= cnt + 6'd1;
          // mac_sum already includes the k=3 term, so the finished dot product lands this edge
          if (k_idx == 2'd3)
            comb_flat[int'({n_idx, j_idx})*OUT_WIDTH +: OUT_WIDTH] <= sat_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_combination_engine.sv
// Randomized and directed checks of combination_engine against a plain-arithmetic matrix model.
module tb_combination_engine;

  localparam int IW = 7;
  localparam int WW = 5;
  localparam int OW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_ready = 1'b0;
  logic [16*IW-1:0]  agg_flat = '0;
  logic              w_we = 1'b0;
  logic [3:0]        w_addr = '0;
  logic [WW-1:0]     w_data = '0;
  logic [16*OW-1:0]  comb_flat;
  logic              out_ready;
  logic              busy;
  logic              err_drop;

  int vectors = 0;
  int miscompares = 0;
  int w_m [16];
  int agg_m [16];
  bit err_m = 1'b0;

  always #5 clk = ~clk;

  combination_engine #(.IN_WIDTH(IW), .W_WIDTH(WW), .OUT_WIDTH(OW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_ready_combination  (in_ready),
    .agg_flat              (agg_flat),
    .w_we                  (w_we),
    .w_addr                (w_addr),
    .w_data                (w_data),
    .comb_flat             (comb_flat),
    .out_ready_combination (out_ready),
    .busy                  (busy),
    .err_drop              (err_drop)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_out();
    logic [127:0] r;
    int s;
    r = '0;
    for (int n = 0; n < 4; n++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += agg_m[n*4+k] * w_m[k*4+j];
        if (s < 0) s = 0;
        if (s > 127) s = 127;
        r[(n*4+j)*8 +: 8] = 8'(s);
      end
    return r;
  endfunction

  task automatic load_weights();
    for (int i = 0; i < 16; i++) begin
      w_we = 1'b1;
      w_addr = 4'(i);
      w_data = 5'(w_m[i]);
      @(posedge clk); #1;
    end
    w_we = 1'b0;
  endtask

  task automatic set_identity();
    for (int i = 0; i < 16; i++) w_m[i] = (i % 5 == 0) ? 1 : 0;
  endtask

  task automatic rand_agg();
    for (int i = 0; i < 16; i++) agg_m[i] = int'($urandom_range(0, 127)) - 64;
  endtask

  task automatic run_graph(input string tag, input int pulse_at, input int wwe_at,
                           input int rst_at, input int co_addr, input int co_data);
    logic [127:0] exp;
    int ready_first;
    int ready_cnt;
    bit aborted;
    ready_first = -1;
    ready_cnt = 0;
    aborted = 1'b0;
    for (int i = 0; i < 16; i++) agg_flat[i*IW +: IW] = 7'(agg_m[i]);
    if (co_addr >= 0) begin
      w_we = 1'b1;
      w_addr = 4'(co_addr);
      w_data = 5'(co_data);
      w_m[co_addr] = co_data;
    end
    exp = model_out();
    in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    w_we = 1'b0;
    for (int i = 1; i <= 68; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_busy"}, 128'(busy), 128'd0);
        chk({tag, "_rst_comb"}, comb_flat, 128'd0);
        chk({tag, "_rst_err"}, 128'(err_drop), 128'd0);
        for (int w = 0; w < 16; w++) w_m[w] = 0;
        err_m = 1'b0;
        aborted = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      if (i == pulse_at) in_ready = 1'b1;
      if (i == wwe_at) begin
        w_we = 1'b1;
        w_addr = 4'd0;
        w_data = 5'd7;
      end
      @(posedge clk); #1;
      in_ready = 1'b0;
      w_we = 1'b0;
      if (i == pulse_at && !aborted) err_m = 1'b1;
      if (out_ready) begin
        ready_cnt++;
        if (ready_first < 0) ready_first = i;
      end
      if (!aborted) begin
        if (i == 1)  chk({tag, "_busy_start"}, 128'(busy), 128'd1);
        if (i == 64) chk({tag, "_comb"}, comb_flat, exp);
        if (i == 65) chk({tag, "_busy_end"}, 128'(busy), 128'd0);
      end
    end
    if (aborted) begin
      chk({tag, "_no_ready"}, 128'(ready_cnt), 128'd0);
      chk({tag, "_comb_after_abort"}, comb_flat, 128'd0);
    end else begin
      chk({tag, "_ready_at"}, 128'(ready_first), 128'd64);
      chk({tag, "_ready_cnt"}, 128'(ready_cnt), 128'd1);
    end
    chk({tag, "_err_drop"}, 128'(err_drop), 128'(err_m));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      w_m[i] = 0;
      agg_m[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_comb", comb_flat, 128'd0);
    chk("reset_ready", 128'(out_ready), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_err", 128'(err_drop), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rand_agg();
    run_graph("zero_w", -1, -1, -1, -1, 0);

    set_identity();
    load_weights();
    for (int i = 0; i < 16; i++) agg_m[i] = 0;
    agg_m[0] = 1; agg_m[1] = 2; agg_m[2] = 3; agg_m[3] = 4;
    run_graph("ident_node0", -1, -1, -1, -1, 0);

    for (int i = 0; i < 16; i++) agg_m[i] = 0;
    agg_m[8] = -5; agg_m[9] = 6; agg_m[10] = -63; agg_m[11] = 63;
    run_graph("ident_node2_relu", -1, -1, -1, -1, 0);

    for (int i = 0; i < 16; i++) begin
      w_m[i] = 15;
      agg_m[i] = 63;
    end
    load_weights();
    run_graph("clamp_max", -1, -1, -1, -1, 0);
    for (int i = 0; i < 16; i++) w_m[i] = -16;
    load_weights();
    run_graph("all_neg_w", -1, -1, -1, -1, 0);

    set_identity();
    load_weights();
    rand_agg();
    run_graph("drop_pulse", 10, -1, -1, -1, 0);
    rand_agg();
    run_graph("ignored_wwe", -1, 5, -1, -1, 0);
    rand_agg();
    run_graph("after_ignored_wwe", -1, -1, -1, -1, 0);
    rand_agg();
    run_graph("same_edge_write", -1, -1, -1, 0, 3);

    rand_agg();
    run_graph("reset_abort", -1, -1, 30, -1, 0);
    rand_agg();
    run_graph("post_reset_zero_w", -1, -1, -1, -1, 0);

    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 16; i++) w_m[i] = int'($urandom_range(0, 31)) - 16;
      load_weights();
      rand_agg();
      run_graph($sformatf("random_%0d", g), -1, -1, -1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
